clock_manager: RTL and testbench
================================

# clock_manager

Parametrised clock-domain supervisor sitting directly after the PLL/global-buffer clock block. It runs on the buffered system clock and watches the PLL lock signal, which it qualifies with a debounce window. From that it produces per-channel synchronous resets, released in a staggered sequence, and per-channel programmable clock-enable strobes, so downstream blocks can run at divided rates without extra PLL outputs. Loss of lock at any point re-asserts all resets and is counted for diagnostics.

## Interface

Parameters:
- NUM_CH, 4: number of reset/clock-enable channels (1..16).
- DIV_W, 16: width of each channel's divide ratio.
- LOCK_CNT, 1024: consecutive synced-lock cycles required before release (>=1).
- RST_STAGGER, 16: cycles between successive channel reset releases (>=1).

Ports:
- i_sys_clk  in  1  buffered system clock; sole clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_pll_lock  in  1  raw PLL LOCK, asynchronous; 2-flop synchronised internally.
- i_div  in  NUM_CH*DIV_W  divide ratios; channel k occupies bits [k*DIV_W +: DIV_W].
- i_div_load  in  1  one-cycle pulse that captures i_div into the pending registers.
- o_locked  out  1  qualified lock.
- o_rst  out  NUM_CH  per-channel synchronous reset, active-high.
- o_ce  out  NUM_CH  per-channel one-cycle clock-enable strobe.
- o_lock_loss_cnt  out  8  saturating count of lock-loss events.

## Operation

- Reset values (while i_rst is high): o_locked=0, o_rst all 1, o_ce all 0, o_lock_loss_cnt=0, FSM=WAIT_LOCK, sync flops 0, active ratios=0, pending ratios=0, no load pending.
- Define lock_s as i_pll_lock after the 2-flop synchroniser.
- FSM states:
  - WAIT_LOCK: o_locked=0, all o_rst=1. Go to STABLE when lock_s=1.
  - STABLE: count cycles with lock_s=1. When the count reaches LOCK_CNT, go to RELEASE. If lock_s=0, go back to WAIT_LOCK with the count cleared. This is not counted as a loss.
  - RELEASE: o_locked=1. Channel k's o_rst falls at RELEASE entry + k*RST_STAGGER cycles. Go to RUN once channel NUM_CH-1 is released.
  - RUN: steady state.
- Lock loss means lock_s=0 while in RELEASE or RUN:
  - Next edge: o_locked=0, all o_rst=1, all o_ce=0, stagger counter cleared, FSM=WAIT_LOCK.
  - o_lock_loss_cnt increments by 1 and saturates at 255.
- Divider, per channel, with D the active ratio for that channel:
  - The counter is held at 0 while o_rst[k]=1.
  - D<=1: o_ce[k]=1 on every cycle that o_rst[k]=0.
  - D>=2: o_ce[k] is high on the D-th cycle after o_rst[k] is low, then on every D-th cycle after that.
- Ratio update:
  - i_div_load copies i_div into the pending registers and sets load-pending on all channels.
  - A channel in reset takes the pending ratio immediately.
  - A running channel takes it at its next wrap, meaning the cycle o_ce[k]=1. The new period starts right after that strobe.
  - i_div_load in the same cycle as a wrap: the new value applies to the period starting immediately.
  - A second i_div_load before a channel has wrapped overwrites its pending value; only the latest is used.
- i_rst asserted mid-operation: all state returns to reset values asynchronously, including o_lock_loss_cnt.

## Timing

- Lock input path: a lock_s change is visible 2 cycles after i_pll_lock changes.
- Release latency: with i_pll_lock stable high from cycle 0, o_locked rises and o_rst[0] falls at cycle 2+LOCK_CNT+1 = LOCK_CNT+3.
- Channel k is released RST_STAGGER*k cycles after channel 0.
- All outputs are registered with no combinational input-to-output paths.
- Lock-loss response: from an i_pll_lock fall to all o_rst high takes 3 cycles.
- o_ce pulses are exactly 1 cycle wide for D>=2.
- Divider jitter is zero: period is exactly D cycles.

## Test plan

- Lock bring-up: NUM_CH=4, LOCK_CNT=8, RST_STAGGER=4, i_pll_lock high at cycle 0 -> o_locked rises at cycle 11; o_rst[3:0] fall at cycles 11, 15, 19, 23.
- Glitchy lock: i_pll_lock high 5 cycles, low 1, then high -> no release until 8 consecutive synced-high cycles; o_lock_loss_cnt stays 0.
- Divide check: ratios {0, 1, 3, 1000} -> ch0 and ch1 strobe every cycle; ch2 strobes on the 3rd, 6th, ... cycle after its release; ch3 every 1000 cycles.
- Runtime reload: ch2 running at D=3, pulse i_div_load with D=5 mid-period -> the remaining period stays 3, then spacing is 5. Repeat with the load coincident with o_ce -> spacing is 5 immediately.
- Lock loss in RUN: drop i_pll_lock -> 3 cycles later all o_rst=1, o_ce=0, o_locked=0, counter=1. Repeat 300 losses -> counter saturates at 255.
- Async reset mid-RELEASE: i_rst pulse between channel 1 and channel 2 release -> all outputs return to reset values in the same cycle, and the full sequence restarts after i_rst falls.

Source files
------------

// File: rtl/clock_manager.sv
// Clock-domain supervisor: debounces PLL lock, sequences staggered per-channel
// resets and generates programmable per-channel clock-enable strobes.
//
// state     | meaning
// WAIT_LOCK | all channels held in reset, waiting for synced lock
// STABLE    | counting consecutive synced-lock cycles
// RELEASE   | locked, releasing channel resets one stagger apart
// RUN       | all channels released, steady state
module clock_manager #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CNT    = 1024,
  parameter int RST_STAGGER = 16
) (
  input  logic                    i_sys_clk,
  input  logic                    i_rst,
  input  logic                    i_pll_lock,
  input  logic [NUM_CH*DIV_W-1:0] i_div,
  input  logic                    i_div_load,
  output logic                    o_locked,
  output logic [NUM_CH-1:0]       o_rst,
  output logic [NUM_CH-1:0]       o_ce,
  output logic [7:0]              o_lock_loss_cnt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int ST_W = (RST_STAGGER > 1) ? $clog2(RST_STAGGER) : 1;

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

  state_t            state;
  logic              lock_s1;
  logic              lock_s;
  logic [LC_W-1:0]   lock_cnt;
  logic [ST_W-1:0]   stag_cnt;
  logic [CH_W-1:0]   next_ch;
  logic              loss;
  logic              rel_first;
  logic              rel_next;
  logic [NUM_CH-1:0] rst_nxt;

  logic [NUM_CH-1:0][DIV_W-1:0] div_act;
  logic [NUM_CH-1:0][DIV_W-1:0] div_pend;
  logic [NUM_CH-1:0][DIV_W-1:0] div_cnt;
  logic [NUM_CH-1:0][DIV_W-1:0] div_eff;
  logic [NUM_CH-1:0]            load_pend;
  logic [NUM_CH-1:0]            take;

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_s1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_s1 <= i_pll_lock;
      lock_s  <= lock_s1;
    end
  end

  assign loss      = !lock_s && (state == RELEASE || state == RUN);
  assign rel_first = lock_s && (state == STABLE) && (lock_cnt == '0);
  assign rel_next  = lock_s && (state == RELEASE) && (stag_cnt == '0);

  // Next reset vector is shared with the dividers so strobes align with release.
  always_comb begin
    rst_nxt = o_rst;
    if (loss)
      rst_nxt = '1;
    else if (rel_first)
      rst_nxt[0] = 1'b0;
    else if (rel_next)
      rst_nxt[next_ch] = 1'b0;
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= WAIT_LOCK;
      lock_cnt        <= '0;
      stag_cnt        <= '0;
      next_ch         <= '0;
      o_locked        <= 1'b0;
      o_rst           <= '1;
      o_lock_loss_cnt <= '0;
    end else begin
      o_rst <= rst_nxt;
      if (loss) begin
        state    <= WAIT_LOCK;
        o_locked <= 1'b0;
        stag_cnt <= '0;
        next_ch  <= '0;
        lock_cnt <= '0;
        if (o_lock_loss_cnt != 8'hFF)
          o_lock_loss_cnt <= o_lock_loss_cnt + 8'd1;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (lock_s) begin
              state    <= STABLE;
              lock_cnt <= LC_W'(LOCK_CNT - 1);
            end
          end
          STABLE: begin
            if (!lock_s) begin
              state    <= WAIT_LOCK;
              lock_cnt <= '0;
            end else if (lock_cnt == '0) begin
              state    <= (NUM_CH == 1) ? RUN : RELEASE;
              o_locked <= 1'b1;
              stag_cnt <= ST_W'(RST_STAGGER - 1);
              next_ch  <= CH_W'(1);
            end else begin
              lock_cnt <= lock_cnt - LC_W'(1);
            end
          end
          RELEASE: begin
            if (stag_cnt == '0) begin
              stag_cnt <= ST_W'(RST_STAGGER - 1);
              if (next_ch == CH_W'(NUM_CH - 1))
                state <= RUN;
              else
                next_ch <= next_ch + CH_W'(1);
            end else begin
              stag_cnt <= stag_cnt - ST_W'(1);
            end
          end
          RUN: begin
          end
          default: state <= WAIT_LOCK;
        endcase
      end
    end
  end

  // A channel adopts a new ratio while in reset or in the cycle its strobe is high;
  // a load arriving in that same cycle wins over an older pending value.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      take[k]    = o_rst[k] | o_ce[k];
      div_eff[k] = div_act[k];
      if (take[k]) begin
        if (i_div_load)
          div_eff[k] = i_div[k*DIV_W +: DIV_W];
        else if (load_pend[k])
          div_eff[k] = div_pend[k];
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      div_act   <= '0;
      div_pend  <= '0;
      div_cnt   <= '0;
      load_pend <= '0;
      o_ce      <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        div_act[k] <= div_eff[k];
        if (i_div_load) begin
          div_pend[k]  <= i_div[k*DIV_W +: DIV_W];
          load_pend[k] <= !take[k];
        end else if (take[k]) begin
          load_pend[k] <= 1'b0;
        end

        if (rst_nxt[k]) begin
          div_cnt[k] <= '0;
          o_ce[k]    <= 1'b0;
        end else if (div_eff[k] <= DIV_W'(1)) begin
          div_cnt[k] <= '0;
          o_ce[k]    <= 1'b1;
        end else if (o_rst[k]) begin
          div_cnt[k] <= '0;
          o_ce[k]    <= 1'b0;
        end else if (div_cnt[k] == div_eff[k] - DIV_W'(1)) begin
          div_cnt[k] <= '0;
          o_ce[k]    <= 1'b1;
        end else begin
          div_cnt[k] <= div_cnt[k] + DIV_W'(1);
          o_ce[k]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_manager.sv
// Scoreboard bench for clock_manager: stimulus queues expected output words for
// specific cycles, a negedge monitor pops and compares them.
module tb_clock_manager;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 16;
  localparam int LOCK_CNT    = 8;
  localparam int RST_STAGGER = 4;

  localparam logic [31:0] M_LOCK = 32'h00001;
  localparam logic [31:0] M_RST  = 32'h0001E;
  localparam logic [31:0] M_CNT  = 32'h1FE00;
  localparam logic [31:0] M_ALL  = 32'h1FFFF;
  localparam logic [31:0] M_CE2  = 32'h00080;
  localparam logic [31:0] M_CE3  = 32'h00100;

  logic                    i_sys_clk = 1'b0;
  logic                    i_rst;
  logic                    i_pll_lock;
  logic [NUM_CH*DIV_W-1:0] i_div;
  logic                    i_div_load;
  logic                    o_locked;
  logic [NUM_CH-1:0]       o_rst;
  logic [NUM_CH-1:0]       o_ce;
  logic [7:0]              o_lock_loss_cnt;

  clock_manager #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CNT(LOCK_CNT), .RST_STAGGER(RST_STAGGER)
  ) dut (
    .i_sys_clk(i_sys_clk), .i_rst(i_rst), .i_pll_lock(i_pll_lock),
    .i_div(i_div), .i_div_load(i_div_load), .o_locked(o_locked),
    .o_rst(o_rst), .o_ce(o_ce), .o_lock_loss_cnt(o_lock_loss_cnt)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  int cyc = 0;
  always @(posedge i_sys_clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] mask;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] w(logic lk, logic [3:0] rs, logic [3:0] ce, logic [7:0] cnt);
    return {15'd0, cnt, ce, rs, lk};
  endfunction

  function automatic logic [7:0] sat(int n);
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  function automatic void exp_at(string name, int c, logic [31:0] mask, logic [31:0] val);
    exp_t e;
    int   i;
    e.name = name;
    e.cyc  = c;
    e.mask = mask;
    e.val  = val & mask;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endfunction

  always @(negedge i_sys_clk) begin : monitor
    logic [31:0] act;
    exp_t        e;
    act = {15'd0, o_lock_loss_cnt, o_ce, o_rst, o_locked};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc == cyc && (act & e.mask) == e.val)
        n_pass++;
      else
        $display("FAIL %s cyc=%0d got=%h expected=%h mask=%h due=%0d",
                 e.name, cyc, act & e.mask, e.val, e.mask, e.cyc);
    end
  end

  task automatic wait_until(int c);
    while (cyc < c) @(negedge i_sys_clk);
  endtask

  task automatic load_div(logic [NUM_CH*DIV_W-1:0] r);
    i_div      = r;
    i_div_load = 1'b1;
    @(negedge i_sys_clk);
    i_div_load = 1'b0;
  endtask

  initial begin
    int   t0, r2, r3, wc, a, g0, lc;
    exp_t e;
    i_rst      = 1'b1;
    i_pll_lock = 1'b0;
    i_div_load = 1'b0;
    i_div      = '0;
    @(negedge i_sys_clk);
    exp_at("reset_state", cyc + 1, M_ALL, w(1'b0, 4'hF, 4'h0, 8'd0));
    wait_until(cyc + 3);
    i_rst = 1'b0;
    wait_until(cyc + 2);

    // Bring-up with ratios {1000, 3, 1, 0} loaded while all channels are in reset
    load_div({16'd1000, 16'd3, 16'd1, 16'd0});
    wait_until(cyc + 2);
    t0 = cyc;
    r2 = t0 + 19;
    r3 = t0 + 23;
    exp_at("up_not_yet",  t0 + 10, M_LOCK | M_RST, w(1'b0, 4'hF, 4'h0, 8'd0));
    exp_at("up_ch0_rel",  t0 + 11, M_ALL, w(1'b1, 4'hE, 4'h1, 8'd0));
    exp_at("up_ch1_hold", t0 + 14, M_ALL, w(1'b1, 4'hE, 4'h1, 8'd0));
    exp_at("up_ch1_rel",  t0 + 15, M_ALL, w(1'b1, 4'hC, 4'h3, 8'd0));
    exp_at("up_ch2_hold", t0 + 18, M_ALL, w(1'b1, 4'hC, 4'h3, 8'd0));
    exp_at("up_ch2_rel",  t0 + 19, M_ALL, w(1'b1, 4'h8, 4'h3, 8'd0));
    exp_at("div3_gap1",   t0 + 20, M_ALL, w(1'b1, 4'h8, 4'h3, 8'd0));
    exp_at("div3_gap2",   t0 + 21, M_ALL, w(1'b1, 4'h8, 4'h3, 8'd0));
    exp_at("div3_first",  t0 + 22, M_ALL, w(1'b1, 4'h8, 4'h7, 8'd0));
    exp_at("up_ch3_rel",  t0 + 23, M_ALL, w(1'b1, 4'h0, 4'h3, 8'd0));
    exp_at("div3_second", t0 + 25, M_ALL, w(1'b1, 4'h0, 4'h7, 8'd0));
    exp_at("div1000_pre", r3 + 999,  M_CE3, 32'h0);
    exp_at("div1000_1st", r3 + 1000, M_CE3, M_CE3);
    exp_at("div1000_pst", r3 + 1001, M_CE3, 32'h0);
    exp_at("div1000_2nd", r3 + 2000, M_CE3, M_CE3);
    i_pll_lock = 1'b1;
    wait_until(r3 + 2002);

    // Runtime reload on ch2: mid-period load, then a load coincident with its strobe
    wc = cyc + 2;
    while ((wc - r2) % 3 != 0) wc++;
    exp_at("reload_rem3",   wc + 3,  M_CE2, M_CE2);
    exp_at("reload_gap4",   wc + 4,  M_CE2, 32'h0);
    exp_at("reload_gap6",   wc + 6,  M_CE2, 32'h0);
    exp_at("reload_gap7",   wc + 7,  M_CE2, 32'h0);
    exp_at("reload_d5",     wc + 8,  M_CE2, M_CE2);
    exp_at("reload_d5_2",   wc + 13, M_CE2, M_CE2);
    exp_at("back_to3_old",  wc + 18, M_CE2, M_CE2);
    exp_at("back_to3_1",    wc + 21, M_CE2, M_CE2);
    exp_at("back_to3_2",    wc + 24, M_CE2, M_CE2);
    exp_at("coinc_no_old3", wc + 27, M_CE2, 32'h0);
    exp_at("coinc_d5",      wc + 29, M_CE2, M_CE2);
    exp_at("coinc_gap",     wc + 32, M_CE2, 32'h0);
    exp_at("coinc_d5_2",    wc + 34, M_CE2, M_CE2);
    wait_until(wc + 1);
    load_div({16'd1000, 16'd5, 16'd1, 16'd0});
    wait_until(wc + 14);
    load_div({16'd1000, 16'd3, 16'd1, 16'd0});
    wait_until(wc + 24);
    load_div({16'd1000, 16'd5, 16'd1, 16'd0});
    wait_until(wc + 36);

    // Lock loss in RUN, then repeated losses up to saturation
    lc = cyc;
    exp_at("loss_pre",  lc + 2, M_LOCK | M_RST, w(1'b1, 4'h0, 4'h0, 8'd0));
    exp_at("loss_resp", lc + 3, M_ALL, w(1'b0, 4'hF, 4'h0, 8'd1));
    i_pll_lock = 1'b0;
    a = lc + 5;
    for (int n = 2; n <= 300; n++) begin
      exp_at("loss_cnt_pre", a + 14, M_CNT | M_LOCK, w(1'b1, 4'h0, 4'h0, sat(n - 1)));
      exp_at("loss_cnt",     a + 15, M_CNT | M_LOCK | M_RST, w(1'b0, 4'hF, 4'h0, sat(n)));
      wait_until(a);
      i_pll_lock = 1'b1;
      wait_until(a + 12);
      i_pll_lock = 1'b0;
      a += 16;
    end
    wait_until(a);

    // Reset clears the loss counter
    exp_at("rst_clears_cnt", cyc + 1, M_ALL, w(1'b0, 4'hF, 4'h0, 8'd0));
    i_rst = 1'b1;
    wait_until(cyc + 2);
    i_rst = 1'b0;
    wait_until(cyc + 2);

    // Glitchy lock, then async reset between ch1 and ch2 release
    g0 = cyc;
    exp_at("glitch_no_rel",   g0 + 11, M_ALL, w(1'b0, 4'hF, 4'h0, 8'd0));
    exp_at("glitch_pre_rel",  g0 + 16, M_LOCK | M_RST, w(1'b0, 4'hF, 4'h0, 8'd0));
    exp_at("glitch_rel",      g0 + 17, M_ALL, w(1'b1, 4'hE, 4'h1, 8'd0));
    exp_at("glitch_ch1_rel",  g0 + 21, M_ALL, w(1'b1, 4'hC, 4'h3, 8'd0));
    exp_at("async_rst",       g0 + 22, M_ALL, w(1'b0, 4'hF, 4'h0, 8'd0));
    exp_at("async_rst_hold",  g0 + 23, M_ALL, w(1'b0, 4'hF, 4'h0, 8'd0));
    exp_at("restart_pre_rel", g0 + 34, M_LOCK | M_RST, w(1'b0, 4'hF, 4'h0, 8'd0));
    exp_at("restart_rel",     g0 + 35, M_ALL, w(1'b1, 4'hE, 4'h1, 8'd0));
    exp_at("restart_ch1",     g0 + 39, M_LOCK | M_RST, w(1'b1, 4'hC, 4'h0, 8'd0));
    exp_at("restart_ch2",     g0 + 43, M_LOCK | M_RST, w(1'b1, 4'h8, 4'h0, 8'd0));
    exp_at("restart_ch3",     g0 + 47, M_ALL, w(1'b1, 4'h0, 4'hF, 8'd0));
    i_pll_lock = 1'b1;
    wait_until(g0 + 5);
    i_pll_lock = 1'b0;
    wait_until(g0 + 6);
    i_pll_lock = 1'b1;
    wait_until(g0 + 21);
    @(posedge i_sys_clk);
    #1;
    i_rst = 1'b1;
    @(negedge i_sys_clk);
    wait_until(g0 + 24);
    i_rst = 1'b0;
    wait_until(g0 + 50);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s never sampled, due=%0d now=%0d", e.name, e.cyc, cyc);
    end
    if (n_checks < 12)
      $display("FAIL only %0d checks were executed", n_checks);
    if (n_pass != n_checks)
      $display("FAIL %0d of %0d checks failed", n_checks - n_pass, n_checks);
    else
      $display("PASS all checks");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
